dom_indep_pipe: RTL and testbench

Parametrised, pipelined domain-oriented-masking (DOM-indep) AND multiplier over `WIDTH` independent bit lanes at arbitrary masking order `ORDER`, i.e. `ORDER+1` shares per operand. All cross-domain and inner-domain products are registered before compression, so the block is glitch-safe with a valid-qualified pipeline. It accepts one new operand pair per cycle and replaces the fixed first-order, single-bit, unqualified gadget in masked S-box and datapath netlists used for leakage evaluation.

---
 rtl/dom_pkg.sv | 27 ++
 rtl/dom_indep_lane.sv | 64 ++++++
 rtl/dom_indep_pipe.sv | 98 +++++++++
 tb/tb_dom_indep_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dom_pkg.sv
// Shared helpers for the DOM-indep multiplier.
// Randomness bookkeeping for share pairs and share/lane bit slicing used by
// dom_indep_lane and dom_indep_pipe. Share s of lane w of a packed operand sits
// at bit s*WIDTH+w. Random pair k of lane w sits at bit k*WIDTH+w.
package dom_pkg;

    // Smallest masking order the gadget supports. Order 0 means no masking.
    localparam int DOM_MIN_ORDER = 1;

    // Number of fresh random bits per lane: one per unordered share pair.
    function automatic int dom_num_rand(input int order);
        return order * (order + 1) / 2;
    endfunction

    // Index of the random bit shared by share pair (i,j), i<j.
    function automatic int dom_rand_idx(input int i, input int j, input int order);
        int ns;
        ns = order + 1;
        return i * ns - i * (i + 1) / 2 + (j - i - 1);
    endfunction

    // LSB position of share s inside a packed NS*WIDTH operand.
    function automatic int dom_share_lsb(input int s, input int width);
        return s * width;
    endfunction

endpackage

// File: rtl/dom_indep_lane.sv
// One bit lane of the DOM-indep AND gadget.
// Every inner and cross product is registered before any XOR compression, so
// that glitches from the two operands cannot combine ahead of the flops.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture a new operand pair into the product flops
//   a, b       : NS shares of each operand, bit s = share s
//   r          : NR fresh random bits, bit k = share pair k
//   c          : NS product shares, compressed combinationally from the flops
module dom_indep_lane
    import dom_pkg::*;
#(
    parameter int ORDER = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic [ORDER:0]                  a,
    input  logic [ORDER:0]                  b,
    input  logic [dom_num_rand(ORDER)-1:0]  r,
    output logic [ORDER:0]                  c
);

    localparam int NS = ORDER + 1;
    // Cross terms stored row-major by owning share i, skipping the diagonal,
    // so the NS-1 terms that compress into c[i] form one contiguous slice.
    localparam int NC = NS * (NS - 1);

    logic [NS-1:0] inner_reg;
    logic [NS-1:0] inner_next;
    logic [NC-1:0] cross_reg;
    logic [NC-1:0] cross_next;

    assign inner_next = a & b;

    for (genvar gi = 0; gi < NS; gi++) begin : g_row
        for (genvar gj = 0; gj < NS; gj++) begin : g_col
            if (gi != gj) begin : g_cross
                localparam int CI = gi * (NS - 1) + ((gj < gi) ? gj : gj - 1);
                // Both (i,j) and (j,i) use the same random bit so it cancels
                // once all shares are combined.
                localparam int K  = (gi < gj) ? dom_rand_idx(gi, gj, ORDER)
                                              : dom_rand_idx(gj, gi, ORDER);
                assign cross_next[CI] = (a[gi] & b[gj]) ^ r[K];
            end
        end
    end

    // Each product bit is its own flop; these must not be merged or retimed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner_reg <= '0;
            cross_reg <= '0;
        end else if (load) begin
            inner_reg <= inner_next;
            cross_reg <= cross_next;
        end
    end

    for (genvar gi = 0; gi < NS; gi++) begin : g_comp
        assign c[gi] = inner_reg[gi] ^ (^cross_reg[gi*(NS-1) +: (NS-1)]);
    end

endmodule

// File: rtl/dom_indep_pipe.sv
// Pipelined DOM-indep masked AND over WIDTH independent lanes at order ORDER.
// Owns the valid pipeline and optional output register; each lane is a
// dom_indep_lane instance. Latency is 1 cycle (OUT_REG=0) or 2 (OUT_REG=1).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : port_a/port_b/port_r valid this cycle
//   port_a/b   : NS*WIDTH operand shares, share s of lane w at bit s*WIDTH+w
//   port_r     : NR*WIDTH randomness, pair k of lane w at bit k*WIDTH+w
//   out_valid  : port_c carries a result
//   port_c     : NS*WIDTH product shares, same layout as port_a
module dom_indep_pipe
    import dom_pkg::*;
#(
    parameter int ORDER   = 1,
    parameter int WIDTH   = 1,
    parameter int OUT_REG = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    input  logic [(ORDER+1)*WIDTH-1:0]              port_a,
    input  logic [(ORDER+1)*WIDTH-1:0]              port_b,
    input  logic [dom_num_rand(ORDER)*WIDTH-1:0]    port_r,
    output logic                                    out_valid,
    output logic [(ORDER+1)*WIDTH-1:0]              port_c
);

    localparam int NS = ORDER + 1;
    localparam int NR = dom_num_rand(ORDER);

    if (ORDER < DOM_MIN_ORDER || WIDTH < 1) begin : g_bad_param
        $error("dom_indep_pipe: ORDER must be >= 1 and WIDTH must be >= 1");
    end

    logic                  valid1_reg;
    logic [NS*WIDTH-1:0]   c_comb;

    for (genvar gw = 0; gw < WIDTH; gw++) begin : g_lane
        logic [NS-1:0] a_l;
        logic [NS-1:0] b_l;
        logic [NS-1:0] c_l;
        logic [NR-1:0] r_l;

        for (genvar gs = 0; gs < NS; gs++) begin : g_share
            assign a_l[gs] = port_a[dom_share_lsb(gs, WIDTH) + gw];
            assign b_l[gs] = port_b[dom_share_lsb(gs, WIDTH) + gw];
            assign c_comb[dom_share_lsb(gs, WIDTH) + gw] = c_l[gs];
        end
        for (genvar gk = 0; gk < NR; gk++) begin : g_rand
            assign r_l[gk] = port_r[gk*WIDTH + gw];
        end

        dom_indep_lane #(
            .ORDER (ORDER)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (in_valid),
            .a     (a_l),
            .b     (b_l),
            .r     (r_l),
            .c     (c_l)
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_reg <= 1'b0;
        end else begin
            valid1_reg <= in_valid;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [NS*WIDTH-1:0] c_reg;
        logic                valid2_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c_reg      <= '0;
                valid2_reg <= 1'b0;
            end else begin
                valid2_reg <= valid1_reg;
                // Only capture fresh stage-1 data so port_c holds between results.
                if (valid1_reg) begin
                    c_reg <= c_comb;
                end
            end
        end

        assign port_c    = c_reg;
        assign out_valid = valid2_reg;
    end else begin : g_no_out_reg
        assign port_c    = c_comb;
        assign out_valid = valid1_reg;
    end

endmodule

// File: tb/tb_dom_indep_pipe.sv
module tb_dom_indep_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    // DUT1: d=1, W=1, OUT_REG=0
    logic        iv1;
    logic [1:0]  a1, b1, c1;
    logic [0:0]  r1;
    logic        ov1;
    // DUT2: d=2, W=4, OUT_REG=0
    logic        iv2;
    logic [11:0] a2, b2, c2, r2;
    logic        ov2;
    // DUT3: d=3, W=2, OUT_REG=1
    logic        iv3;
    logic [7:0]  a3, b3, c3;
    logic [11:0] r3;
    logic        ov3;

    dom_indep_pipe #(.ORDER(1), .WIDTH(1), .OUT_REG(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .port_a(a1), .port_b(b1),
        .port_r(r1), .out_valid(ov1), .port_c(c1));
    dom_indep_pipe #(.ORDER(2), .WIDTH(4), .OUT_REG(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .port_a(a2), .port_b(b2),
        .port_r(r2), .out_valid(ov2), .port_c(c2));
    dom_indep_pipe #(.ORDER(3), .WIDTH(2), .OUT_REG(1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .port_a(a3), .port_b(b3),
        .port_r(r3), .out_valid(ov3), .port_c(c3));

    logic [63:0] q1[$];
    logic [63:0] q2[$];
    logic [7:0]  u2[$];
    logic [63:0] q3[$];

    // Reference share-level model: pairs are numbered by enumerating i<j in order.
    function automatic logic [63:0] model_c(input int ns, input int w,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] r);
        logic [63:0] c;
        logic        rb[8][8];
        logic        acc;
        int          kk;
        c = '0;
        for (int l = 0; l < w; l++) begin
            kk = 0;
            for (int i = 0; i < ns; i++)
                for (int j = i + 1; j < ns; j++) begin
                    rb[i][j] = r[kk*w+l];
                    rb[j][i] = r[kk*w+l];
                    kk++;
                end
            for (int i = 0; i < ns; i++) begin
                acc = a[i*w+l] & b[i*w+l];
                for (int j = 0; j < ns; j++)
                    if (j != i) acc ^= (a[i*w+l] & b[j*w+l]) ^ rb[i][j];
                c[i*w+l] = acc;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] unmask(input int ns, input int w, input logic [63:0] v);
        logic [7:0] u;
        u = '0;
        for (int s = 0; s < ns; s++)
            for (int l = 0; l < w; l++) u[l] ^= v[s*w+l];
        return u;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        iv1 = 0; a1 = '0; b1 = '0; r1 = '0;
        iv2 = 0; a2 = '0; b2 = '0; r2 = '0;
        iv3 = 0; a3 = '0; b3 = '0; r3 = '0;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 0;
        #2;
        total++;
        if (ov1 !== 1'b0 || ov2 !== 1'b0 || ov3 !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: ov1=%b ov2=%b ov3=%b required 0", ov1, ov2, ov3);
        end
        total++;
        if (c1 !== '0 || c2 !== '0 || c3 !== '0) begin
            bad++;
            $display("FAIL reset_data: c1=%h c2=%h c3=%h required 0", c1, c2, c3);
        end
        step(); step();
        rst_n = 1;
        step();
        $display("reset: ov1=%b c1=%h c2=%h c3=%h", ov1, c1, c2, c3);
    endtask

    task automatic test_single();
        logic [63:0] exp_c;
        a1 = 2'b01; b1 = 2'b10; r1 = 1'b1; iv1 = 1;
        q1.push_back(model_c(2, 1, 64'(a1), 64'(b1), 64'(r1)));
        step();
        iv1 = 0;
        total++;
        if (ov1 !== 1'b1) begin
            bad++;
            $display("FAIL single_valid: out_valid=%b required 1", ov1);
        end else begin
            exp_c = q1.pop_front();
            total++;
            if (c1 !== 2'b10 || 64'(c1) !== exp_c) begin
                bad++;
                $display("FAIL single_data: port_c=%b required 10 (model %b)", c1, exp_c[1:0]);
            end
        end
        $display("single: out_valid=%b port_c=%b", ov1, c1);
        step();
        total++;
        if (ov1 !== 1'b0 || c1 !== 2'b10) begin
            bad++;
            $display("FAIL single_hold: out_valid=%b port_c=%b required 0/10", ov1, c1);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_c;
        logic [7:0]  exp_u;
        int          run;
        run = 0;
        total++;
        if (ov2 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pre: out_valid=%b required 0", ov2);
        end
        for (int n = 0; n < 200; n++) begin
            a2 = 12'($urandom); b2 = 12'($urandom); r2 = 12'($urandom); iv2 = 1;
            q2.push_back(model_c(3, 4, 64'(a2), 64'(b2), 64'(r2)));
            u2.push_back(unmask(3, 4, 64'(a2)) & unmask(3, 4, 64'(b2)));
            step();
            total++;
            if (ov2 !== 1'b1 || q2.size() == 0) begin
                bad++;
                $display("FAIL b2b_valid: op=%0d out_valid=%b required 1", n, ov2);
            end else begin
                run++;
                exp_c = q2.pop_front();
                exp_u = u2.pop_front();
                total++;
                if (unmask(3, 4, 64'(c2)) !== exp_u) begin
                    bad++;
                    $display("FAIL b2b_unmask: op=%0d got=%h required=%h", n,
                             unmask(3, 4, 64'(c2)), exp_u);
                end
                total++;
                if (64'(c2) !== exp_c) begin
                    bad++;
                    $display("FAIL b2b_shares: op=%0d got=%h required=%h", n, c2, exp_c[11:0]);
                end
                if (n < 4 || n == 199)
                    $display("b2b op=%0d port_c=%h unmasked=%h", n, c2, unmask(3, 4, 64'(c2)));
            end
        end
        iv2 = 0;
        step();
        total++;
        if (ov2 !== 1'b0 || run != 200) begin
            bad++;
            $display("FAIL b2b_end: out_valid=%b run=%0d required 0/200", ov2, run);
        end
    endtask

    task automatic test_all_pairs();
        logic [1:0] c_r[2];
        for (int ab = 0; ab < 16; ab++) begin
            for (int rv = 0; rv < 2; rv++) begin
                a1 = 2'(ab); b1 = 2'(ab >> 2); r1 = 1'(rv); iv1 = 1;
                q1.push_back(model_c(2, 1, 64'(a1), 64'(b1), 64'(r1)));
                step();
                iv1 = 0;
                total++;
                if (ov1 !== 1'b1 || q1.size() == 0) begin
                    bad++;
                    $display("FAIL pairs_valid: ab=%0d r=%0d out_valid=%b required 1", ab, rv, ov1);
                end else begin
                    total++;
                    if (64'(c1) !== q1.pop_front()) begin
                        bad++;
                        $display("FAIL pairs_shares: ab=%0d r=%0d port_c=%b", ab, rv, c1);
                    end
                end
                c_r[rv] = c1;
                step();
            end
            total++;
            if (c_r[0] === c_r[1]) begin
                bad++;
                $display("FAIL pairs_rdiff: ab=%0d c(r=0)=%b c(r=1)=%b required different",
                         ab, c_r[0], c_r[1]);
            end
            total++;
            if ((^c_r[0]) !== (^c_r[1]) || (^c_r[0]) !== ((^ab[1:0]) & (^ab[3:2]))) begin
                bad++;
                $display("FAIL pairs_unmask: ab=%0d got r0=%b r1=%b required %b", ab,
                         ^c_r[0], ^c_r[1], (^ab[1:0]) & (^ab[3:2]));
            end
            $display("pairs ab=%0d c(r0)=%b c(r1)=%b", ab, c_r[0], c_r[1]);
        end
    endtask

    task automatic test_bubbles();
        logic pat[5];
        logic exp_v;
        logic [63:0] exp_c;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 7; t++) begin
            if (t < 5) iv3 = pat[t]; else iv3 = 0;
            a3 = 8'($urandom); b3 = 8'($urandom); r3 = 12'($urandom);
            if (iv3) q3.push_back(model_c(4, 2, 64'(a3), 64'(b3), 64'(r3)));
            step();
            exp_v = (t >= 1 && t <= 5) ? pat[t-1] : 1'b0;
            total++;
            if (ov3 !== exp_v) begin
                bad++;
                $display("FAIL bubble_valid: t=%0d out_valid=%b required %b", t, ov3, exp_v);
            end else if (ov3) begin
                exp_c = q3.pop_front();
                total++;
                if (64'(c3) !== exp_c) begin
                    bad++;
                    $display("FAIL bubble_data: t=%0d port_c=%h required %h", t, c3, exp_c[7:0]);
                end
            end
            $display("bubble t=%0d out_valid=%b port_c=%h", t, ov3, c3);
        end
        total++;
        if (q3.size() != 0) begin
            bad++;
            $display("FAIL bubble_drain: %0d results missing, required 0", q3.size());
        end
        iv3 = 0;
    endtask

    task automatic test_reset_midflight();
        a1 = 2'b01; b1 = 2'b01; r1 = 1'b0; iv1 = 1;
        a3 = 8'hff; b3 = 8'h03; r3 = 12'h0; iv3 = 1;
        step();
        iv1 = 0; iv3 = 0;
        total++;
        if (ov1 !== 1'b1 || c1 !== 2'b01) begin
            bad++;
            $display("FAIL midrst_pre: out_valid=%b port_c=%b required 1/01", ov1, c1);
        end
        rst_n = 0;
        #2;
        total++;
        if (ov1 !== 1'b0 || c1 !== 2'b00 || ov3 !== 1'b0 || c3 !== 8'h00) begin
            bad++;
            $display("FAIL midrst_async: ov1=%b c1=%b ov3=%b c3=%h required all 0", ov1, c1, ov3, c3);
        end
        step();
        rst_n = 1;
        for (int t = 0; t < 3; t++) begin
            step();
            total++;
            if (ov1 !== 1'b0 || ov3 !== 1'b0) begin
                bad++;
                $display("FAIL midrst_after: t=%0d ov1=%b ov3=%b required 0", t, ov1, ov3);
            end
        end
        $display("midrst: ov1=%b c1=%b ov3=%b c3=%h", ov1, c1, ov3, c3);
    endtask

    task automatic test_hold();
        logic [1:0] held;
        a1 = 2'b11; b1 = 2'b10; r1 = 1'b1; iv1 = 1;
        q1.push_back(model_c(2, 1, 64'(a1), 64'(b1), 64'(r1)));
        step();
        iv1 = 0;
        total++;
        if (ov1 !== 1'b1 || 64'(c1) !== q1.pop_front()) begin
            bad++;
            $display("FAIL hold_load: out_valid=%b port_c=%b", ov1, c1);
        end
        held = c1;
        for (int t = 0; t < 8; t++) begin
            a1 = 2'($urandom); b1 = 2'($urandom); r1 = 1'($urandom);
            #1;
            total++;
            if (c1 !== held) begin
                bad++;
                $display("FAIL hold_comb: t=%0d port_c=%b required %b", t, c1, held);
            end
            step();
            total++;
            if (ov1 !== 1'b0 || c1 !== held) begin
                bad++;
                $display("FAIL hold_edge: t=%0d out_valid=%b port_c=%b required 0/%b", t, ov1, c1, held);
            end
        end
        $display("hold: port_c=%b", c1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_all_pairs();
        test_bubbles();
        test_reset_midflight();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
